// File: rtl/mem_stage_ctrl.sv
// Purpose : MEM-stage controller; runs loads/stores on a req/ack data bus and feeds write-back.
// Latency : non-memory ops 1 cycle; memory ops stall 1 + (WAIT cycles, at most TIMEOUT) cycles.
// Backpr. : freeze holds EXE2MEM and earlier stages while an access is in flight; WB sees bubbles.
//
// Ports
//   clk, rst                         clock, async active-low reset
//   WB_EN, Mem_Read_EN, Mem_Write_EN EXE2MEM control
//   ALU_Result, Store_Value, Dest    EXE2MEM data (ALU_Result is the byte address for memory ops)
//   freeze                           combinational stall to upstream stages
//   mem_req/we/addr/wdata            registered data-bus request (word address)
//   mem_rdata, mem_ack               bus response; ack is a one-cycle pulse
//   WB_EN_out .. Dest_out            registered MEM2WB outputs
//   misalign_err, bus_err            registered one-cycle error pulses
module mem_stage_ctrl #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int TIMEOUT           = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_EN,
    input  logic                         Mem_Read_EN,
    input  logic                         Mem_Write_EN,
    input  logic [WORD_LEN-1:0]          ALU_Result,
    input  logic [WORD_LEN-1:0]          Store_Value,
    input  logic [REG_FILE_ADDR_LEN-1:0] Dest,
    output logic                         freeze,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WORD_LEN-3:0]          mem_addr,
    output logic [WORD_LEN-1:0]          mem_wdata,
    input  logic [WORD_LEN-1:0]          mem_rdata,
    input  logic                         mem_ack,
    output logic                         WB_EN_out,
    output logic                         MEM_R_EN_out,
    output logic [WORD_LEN-1:0]          ALU_Result_out,
    output logic [WORD_LEN-1:0]          Mem_Read_Value,
    output logic [REG_FILE_ADDR_LEN-1:0] Dest_out,
    output logic                         misalign_err,
    output logic                         bus_err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         mem_req_q, mem_req_d;
    logic                         mem_we_q, mem_we_d;
    logic [WORD_LEN-3:0]          mem_addr_q, mem_addr_d;
    logic [WORD_LEN-1:0]          mem_wdata_q, mem_wdata_d;
    logic [WORD_LEN-1:0]          rd_cap_q, rd_cap_d;
    logic                         wb_en_q, wb_en_d;
    logic                         mrd_en_q, mrd_en_d;
    logic [WORD_LEN-1:0]          alu_q, alu_d;
    logic [WORD_LEN-1:0]          mrv_q, mrv_d;
    logic [REG_FILE_ADDR_LEN-1:0] dest_q, dest_d;
    logic                         misalign_q, misalign_d;
    logic                         bus_err_q, bus_err_d;

    logic op;
    logic misaligned;
    logic timeout_hit;

    assign op          = Mem_Read_EN | Mem_Write_EN;
    // A dual-enable op is executed as a write but still flagged.
    assign misaligned  = (ALU_Result[1:0] != 2'b00) | (Mem_Read_EN & Mem_Write_EN);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (op) state_d = S_WAIT;
            S_WAIT:  if (mem_ack || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath next values
    always_comb begin
        freeze      = 1'b0;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_cap_d    = rd_cap_q;
        wb_en_d     = wb_en_q;
        mrd_en_d    = mrd_en_q;
        alu_d       = alu_q;
        mrv_d       = mrv_q;
        dest_d      = dest_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op) begin
                    freeze      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = Mem_Write_EN;
                    mem_addr_d  = ALU_Result[WORD_LEN-1:2];
                    mem_wdata_d = Store_Value;
                    cnt_d       = '0;
                    misalign_d  = misaligned;
                    wb_en_d     = 1'b0;
                    mrd_en_d    = 1'b0;
                end else begin
                    // Pass-through; the read value keeps whatever the last load left.
                    wb_en_d  = WB_EN;
                    mrd_en_d = Mem_Read_EN;
                    alu_d    = ALU_Result;
                    dest_d   = Dest;
                end
            end
            S_WAIT: begin
                freeze   = 1'b1;
                wb_en_d  = 1'b0;
                mrd_en_d = 1'b0;
                // An ack on the final allowed cycle wins over the timeout.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        rd_cap_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rd_cap_d  = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Upstream inputs are still the frozen instruction here.
                wb_en_d  = WB_EN;
                mrd_en_d = Mem_Read_EN;
                alu_d    = ALU_Result;
                dest_d   = Dest;
                mrv_d    = rd_cap_q;
            end
            default: begin
                wb_en_d  = 1'b0;
                mrd_en_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_cap_q    <= '0;
            wb_en_q     <= 1'b0;
            mrd_en_q    <= 1'b0;
            alu_q       <= '0;
            mrv_q       <= '0;
            dest_q      <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_cap_q    <= rd_cap_d;
            wb_en_q     <= wb_en_d;
            mrd_en_q    <= mrd_en_d;
            alu_q       <= alu_d;
            mrv_q       <= mrv_d;
            dest_q      <= dest_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign WB_EN_out      = wb_en_q;
    assign MEM_R_EN_out   = mrd_en_q;
    assign ALU_Result_out = alu_q;
    assign Mem_Read_Value = mrv_q;
    assign Dest_out       = dest_q;
    assign misalign_err   = misalign_q;
    assign bus_err        = bus_err_q;

endmodule
